// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with per-digit PWM dimming,
// leading-zero suppression, blanking and frame-coherent input snapshots.
module seg7_scan_driver #(
  parameter int DIGITS  = 4,
  parameter int DIV_SUB = 3125
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic [3:0]            brightness,
  output logic [DIGITS-1:0]     pos_ctrl,
  output logic [7:0]            num_ctrl,
  output logic                  frame_done
);

  localparam int SW = (DIV_SUB > 1) ? $clog2(DIV_SUB) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [SW-1:0] SUB_MAX = SW'(DIV_SUB - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic                r_run;
  logic [SW-1:0]       r_sub;
  logic [3:0]          r_phase;
  logic [IW-1:0]       r_idx;

  logic [4*DIGITS-1:0] r_data;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_blank;
  logic                r_lz;
  logic [3:0]          r_bright;

  logic                w_sub_wrap;
  logic                w_slot_end;
  logic                w_frame_wrap;
  logic                w_load;
  logic [DIGITS-1:0]   w_sup;
  logic                w_lead;
  logic [3:0]          w_nib;
  logic                w_lit;

  function automatic logic [6:0] seg_hex(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Counters hold for the first cycle after reset so the very first
  // slot is driven from a valid snapshot rather than cleared registers.
  assign w_sub_wrap   = r_run && (r_sub == SUB_MAX);
  assign w_slot_end   = w_sub_wrap && (r_phase == 4'hF);
  assign w_frame_wrap = w_slot_end && (r_idx == IDX_MAX);
  assign w_load       = !r_run || w_frame_wrap;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_run   <= 1'b0;
      r_sub   <= '0;
      r_phase <= '0;
      r_idx   <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (w_sub_wrap) r_sub <= '0;
        else            r_sub <= r_sub + 1'b1;
        if (w_sub_wrap) r_phase <= r_phase + 1'b1;
        if (w_slot_end) begin
          if (r_idx == IDX_MAX) r_idx <= '0;
          else                  r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_data   <= '0;
      r_dp     <= '0;
      r_blank  <= '0;
      r_lz     <= 1'b0;
      r_bright <= '0;
    end else if (w_load) begin
      r_data   <= disp_data;
      r_dp     <= dp;
      r_blank  <= blank;
      r_lz     <= lz_en;
      r_bright <= brightness;
    end
  end

  always_comb begin
    w_sup  = '0;
    w_lead = r_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (r_data[4*i +: 4] != 4'h0 || r_dp[i])
        w_lead = 1'b0;
      w_sup[i] = w_lead;
    end
  end

  assign w_nib = r_data[4*r_idx +: 4];
  assign w_lit = r_run && (r_phase <= r_bright) &&
                 !r_blank[r_idx] && !w_sup[r_idx];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pos_ctrl   <= '1;
      num_ctrl   <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_frame_wrap;
      if (w_lit) begin
        pos_ctrl <= ~(DIGITS'(1) << r_idx);
        num_ctrl <= {~r_dp[r_idx], seg_hex(w_nib)};
      end else begin
        pos_ctrl <= '1;
        num_ctrl <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame/slot arithmetic model
// predicts every output cycle; a monitor pops and compares.
module tb_seg7_scan_driver;

  localparam int D     = 4;
  localparam int DS    = 2;
  localparam int SLOT  = 16 * DS;
  localparam int FRAME = D * SLOT;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [D-1:0] pos;
    logic [7:0]   num;
    logic         fd;
  } exp_t;

  logic           clk = 1'b0;
  logic           clr = 1'b1;
  logic [4*D-1:0] disp_data = '0;
  logic [D-1:0]   dp = '0;
  logic [D-1:0]   blank = '0;
  logic           lz_en = 1'b0;
  logic [3:0]     brightness = '0;
  logic [D-1:0]   pos_ctrl;
  logic [7:0]     num_ctrl;
  logic           frame_done;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(D), .DIV_SUB(DS)) dut (
    .clk        (clk),
    .clr        (clr),
    .disp_data  (disp_data),
    .dp         (dp),
    .blank      (blank),
    .lz_en      (lz_en),
    .brightness (brightness),
    .pos_ctrl   (pos_ctrl),
    .num_ctrl   (num_ctrl),
    .frame_done (frame_done)
  );

  // Reference model: k counts clock edges since reset release.
  int             k = 0;
  logic [4*D-1:0] s_data;
  logic [D-1:0]   s_dp, s_blank;
  logic           s_lz;
  logic [3:0]     s_br;

  initial forever begin
    exp_t e;
    int t, f, d, ph, nib;
    bit sup;
    @(posedge clk or posedge clr);
    if (clr) begin
      k = 0;
      q.delete();
    end else begin
      k++;
      e.pos = '1;
      e.num = 8'hFF;
      e.fd  = (k > FRAME) && ((k - 1) % FRAME == 0);
      if (k >= 2) begin
        t  = k - 2;
        f  = t % FRAME;
        d  = f / SLOT;
        ph = (f % SLOT) / DS;
        nib = int'(s_data >> (4 * d)) & 15;
        sup = s_lz && (d != 0);
        for (int j = d; j < D; j++)
          if (((int'(s_data >> (4 * j)) & 15) != 0) || s_dp[j])
            sup = 1'b0;
        if (ph <= int'(s_br) && !s_blank[d] && !sup) begin
          e.pos = ~(4'b1 << d);
          e.num = {~s_dp[d], HEX[nib]};
        end
      end
      q.push_back(e);
      if ((k - 1) % FRAME == 0) begin
        s_data  = disp_data;
        s_dp    = dp;
        s_blank = blank;
        s_lz    = lz_en;
        s_br    = brightness;
      end
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!clr) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
      end else begin
        e = q.pop_front();
        if (pos_ctrl !== e.pos || num_ctrl !== e.num ||
            frame_done !== e.fd) begin
          errors++;
          $display("FAIL scan k=%0d t=%0t: got %b/%h/%b expected %b/%h/%b",
                   k, $time, pos_ctrl, num_ctrl, frame_done,
                   e.pos, e.num, e.fd);
        end
      end
      checks++;
      if ($countones(~pos_ctrl) > 1) begin
        errors++;
        $display("FAIL onehot t=%0t: pos_ctrl %b, expected <=1 low",
                 $time, pos_ctrl);
      end
    end
  end

  task automatic set_in(input logic [15:0] dd, input logic [3:0] pp,
                        input logic [3:0] bb, input logic lz,
                        input logic [3:0] br);
    @(negedge clk);
    disp_data  = dd;
    dp         = pp;
    blank      = bb;
    lz_en      = lz;
    brightness = br;
  endtask

  task automatic check_dark(input string name);
    checks++;
    if (pos_ctrl !== 4'hF || num_ctrl !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got %b/%h/%b expected 1111/ff/0",
               name, pos_ctrl, num_ctrl, frame_done);
    end
  endtask

  task automatic async_clear(input string name);
    @(posedge clk);
    #3 clr = 1'b1;
    #1 check_dark(name);
    #3 clr = 1'b0;
  endtask

  initial begin
    #12 check_dark("reset_state");
    set_in(16'h1a9b, 4'h0, 4'h0, 1'b0, 4'hF);
    clr = 1'b0;
    repeat (2 * FRAME + 5) @(posedge clk);
    set_in(16'h0007, 4'h0, 4'h0, 1'b1, 4'hF);
    repeat (FRAME + 40) @(posedge clk);
    set_in(16'h0000, 4'h0, 4'h0, 1'b1, 4'hF);
    repeat (FRAME) @(posedge clk);
    set_in(16'h1a9b, 4'h0, 4'h0, 1'b0, 4'h3);
    repeat (FRAME) @(posedge clk);
    set_in(16'h1a9b, 4'h0, 4'h0, 1'b0, 4'h0);
    repeat (FRAME) @(posedge clk);
    set_in(16'h1a9b, 4'b0100, 4'b0010, 1'b0, 4'hF);
    repeat (FRAME + 17) @(posedge clk);
    set_in(16'h0a00, 4'b0001, 4'b0000, 1'b1, 4'h7);
    repeat (FRAME) @(posedge clk);
    for (int n = 0; n < 24; n++) begin
      set_in(16'($urandom), 4'($urandom), 4'($urandom & $urandom),
             1'($urandom), 4'($urandom));
      repeat ($urandom_range(10, 200)) @(posedge clk);
    end
    repeat ($urandom_range(40, 90)) @(posedge clk);
    async_clear("async_clear_1");
    set_in(16'h3c5e, 4'b1000, 4'b0000, 1'b0, 4'hA);
    repeat (FRAME + 50) @(posedge clk);
    async_clear("async_clear_2");
    for (int n = 0; n < 6; n++) begin
      set_in(16'($urandom), 4'($urandom), 4'($urandom & $urandom),
             1'($urandom), 4'($urandom));
      repeat ($urandom_range(60, 260)) @(posedge clk);
    end
    repeat (FRAME + 3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
